// File: rtl/rs_pkg.sv
// Shared types for the integer-ALU reservation station: operand/entry structs,
// data and tag widths, and the ALU opcode enumeration.
package rs_pkg;

    localparam int WIDTH = 31;  // data MSB index
    localparam int ROB   = 2;   // ROB tag MSB index
    localparam int OP_W  = 4;   // ALU opcode width

    typedef logic [WIDTH:0] data_t;
    typedef logic [ROB:0]   tag_t;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic  rdy;
        tag_t  tag;
        data_t value;
    } rsOperand_t;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        tag_t              dest;
        rsOperand_t        src1;
        rsOperand_t        src2;
    } rsEntry_t;

    // An operand still waiting on a tag grabs the CDB value when the tag is broadcast.
    function automatic rsOperand_t capture(rsOperand_t o, logic cdb_valid, tag_t cdb_tag,
                                           data_t cdb_value);
        rsOperand_t r;
        r = o;
        if (!o.rdy && cdb_valid && (o.tag == cdb_tag)) begin
            r.rdy   = 1'b1;
            r.value = cdb_value;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue bundle of the ALU reservation station.
// slave = station side, master = rename/CDB/ALU environment side.
interface alu_reservation_station_if;
    import rs_pkg::*;

    logic            dispatch;
    logic [OP_W-1:0] aluOp;
    tag_t            robDest;
    data_t           instrValue1;
    data_t           instrValue2;
    logic            ready1;
    logic            ready2;
    tag_t            rob1;
    tag_t            rob2;
    logic            full;

    logic            cdbValid;
    tag_t            cdbTag;
    data_t           cdbValue;

    logic            issueValid;
    logic            issueReady;
    logic [OP_W-1:0] issueOp;
    data_t           issueA;
    data_t           issueB;
    tag_t            issueTag;

    modport slave (
        input  dispatch, aluOp, robDest, instrValue1, instrValue2, ready1, ready2, rob1, rob2,
        input  cdbValid, cdbTag, cdbValue, issueReady,
        output full, issueValid, issueOp, issueA, issueB, issueTag
    );

    modport master (
        output dispatch, aluOp, robDest, instrValue1, instrValue2, ready1, ready2, rob1, rob2,
        output cdbValid, cdbTag, cdbValue, issueReady,
        input  full, issueValid, issueOp, issueA, issueB, issueTag
    );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: one-hot grant, binary index and any-request flag.
module rs_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station: dispatch into lowest free slot, CDB wakeup,
// fixed lowest-index issue select. Option macro: RS_WAKE_ISSUE_BYPASS_EN.
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    alu_reservation_station_if.slave    bus
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    rsEntry_t         slot_q [ENTRIES];
    logic             hold_q;
    logic [IDX_W-1:0] hold_idx_q;

    logic [ENTRIES-1:0] busy;
    logic [ENTRIES-1:0] ready_req;
    logic [ENTRIES-1:0] free_onehot;
    logic [ENTRIES-1:0] ready_onehot;
    logic [ENTRIES-1:0] clr_onehot;
    logic [IDX_W-1:0]   free_idx_unused;
    logic [IDX_W-1:0]   ready_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_any;
    logic               ready_any;
    logic               sel_any;
    logic               full;
    logic               issue_fire;
    logic               do_dispatch;
    rsEntry_t           sel_entry;
    rsEntry_t           new_entry;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            busy[i] = slot_q[i].busy;
`ifdef RS_WAKE_ISSUE_BYPASS_EN
            ready_req[i] = slot_q[i].busy
                && (slot_q[i].src1.rdy || (bus.cdbValid && slot_q[i].src1.tag == bus.cdbTag))
                && (slot_q[i].src2.rdy || (bus.cdbValid && slot_q[i].src2.tag == bus.cdbTag));
`else
            ready_req[i] = slot_q[i].busy && slot_q[i].src1.rdy && slot_q[i].src2.rdy;
`endif
        end
    end

    rs_prio_enc #(.N(ENTRIES)) u_free_enc (
        .req    (~busy),
        .onehot (free_onehot),
        .idx    (free_idx_unused),
        .any    (free_any)
    );

    rs_prio_enc #(.N(ENTRIES)) u_ready_enc (
        .req    (ready_req),
        .onehot (ready_onehot),
        .idx    (ready_idx),
        .any    (ready_any)
    );

    // A stalled presentation is pinned so the ALU sees stable fields until it accepts.
    assign sel_idx     = hold_q ? hold_idx_q : ready_idx;
    assign sel_any     = hold_q || ready_any;
    assign sel_entry   = slot_q[sel_idx];
    assign full        = !free_any;
    assign issue_fire  = sel_any && bus.issueReady;
    assign do_dispatch = bus.dispatch && !full && !flush;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            clr_onehot[i] = hold_q ? (hold_idx_q == IDX_W'(i)) : ready_onehot[i];
        end
    end

    always_comb begin
        new_entry.busy = 1'b1;
        new_entry.op   = bus.aluOp;
        new_entry.dest = bus.robDest;
        new_entry.src1 = capture('{rdy: bus.ready1, tag: bus.rob1, value: bus.instrValue1},
                                 bus.cdbValid, bus.cdbTag, bus.cdbValue);
        new_entry.src2 = capture('{rdy: bus.ready2, tag: bus.rob2, value: bus.instrValue2},
                                 bus.cdbValid, bus.cdbTag, bus.cdbValue);
    end

    always_comb begin
        bus.full       = full;
        bus.issueValid = sel_any;
        bus.issueOp    = '0;
        bus.issueA     = '0;
        bus.issueB     = '0;
        bus.issueTag   = '0;
        if (sel_any) begin
            bus.issueOp  = sel_entry.op;
            bus.issueTag = sel_entry.dest;
`ifdef RS_WAKE_ISSUE_BYPASS_EN
            bus.issueA   = sel_entry.src1.rdy ? sel_entry.src1.value : bus.cdbValue;
            bus.issueB   = sel_entry.src2.rdy ? sel_entry.src2.value : bus.cdbValue;
`else
            bus.issueA   = sel_entry.src1.value;
            bus.issueB   = sel_entry.src2.value;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // NOTE: whole entries are cleared, not just busy, so every field is deterministic after reset or flush.
            for (int i = 0; i < ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (do_dispatch && free_onehot[i]) begin
                    slot_q[i] <= new_entry;
                end else if (slot_q[i].busy) begin
                    slot_q[i].src1 <= capture(slot_q[i].src1, bus.cdbValid, bus.cdbTag, bus.cdbValue);
                    slot_q[i].src2 <= capture(slot_q[i].src2, bus.cdbValid, bus.cdbTag, bus.cdbValue);
                    if (issue_fire && clr_onehot[i]) begin
                        slot_q[i].busy <= 1'b0;
                    end
                end
            end
            hold_q     <= sel_any && !bus.issueReady;
            hold_idx_q <= sel_idx;
        end
    end

    // A dispatch against a full station is only tolerated when a slot frees or flush hits that edge.
    always_ff @(posedge clk) begin
        if (!reset && !flush && !issue_fire) begin
            assert (!(bus.dispatch && full)) else $error("dispatch while reservation station full");
        end
    end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Integer-ALU reservation station sitting directly downstream of the rename-stage operand-value logic. It accepts renamed instructions with their source values or ROB tags and ready flags. It captures missing operands from the common data bus (CDB) and issues one fully-ready instruction per cycle to the ALU under a valid/ready handshake. Branch mispredict recovery clears it via a flush input.

## Interface
- WIDTH, 31, data MSB index (32-bit operands)
- ROB, 2, ROB tag MSB index (8 ROB entries)
- ENTRIES, 4, number of station slots (power of two, ≥2)
- OP_W, 4, ALU opcode width

- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- flush  in  1  mispredict recovery; clears all slots
- dispatch  in  1  rename stage presents an instruction this cycle
- aluOp  in  OP_W  ALU operation
- robDest  in  ROB+1  ROB tag of the instruction's result
- instrValue1, instrValue2  in  WIDTH+1  source values (valid when the matching ready bit is 1)
- ready1, ready2  in  1  source value present
- rob1, rob2  in  ROB+1  producing ROB tag for each source (used when not ready)
- full  out  1  no free slot; rename stage must not dispatch
- cdbValid  in  1  CDB broadcast valid
- cdbTag  in  ROB+1  ROB tag being broadcast
- cdbValue  in  WIDTH+1  broadcast result
- issueValid  out  1  an issued instruction is presented
- issueReady  in  1  ALU accepts this cycle
- issueOp  out  OP_W; issueA, issueB  out  WIDTH+1; issueTag  out  ROB+1  issued instruction fields

## Operation
- Slot state: busy, op, dest tag, and per operand {rdy, tag, value}.
- Dispatch: if dispatch && !full && !flush, write the lowest-index free slot. Each operand not ready and matching cdbTag with cdbValid in the same cycle is written ready with cdbValue.
- Dispatch with full=1 is ignored. The rename stage guarantees this does not happen; an assertion flags it.
- Wakeup: every cycle, each busy slot operand with rdy=0 and tag==cdbTag while cdbValid=1 captures cdbValue and sets rdy. Multiple slots may wake on one broadcast.
- Select: the lowest-index busy slot with both operands rdy drives the issue outputs. The slot clears at the clock edge where issueValid && issueReady. Priority is fixed and not age-ordered.
- Issue outputs stay stable while issueValid && !issueReady, unless flush asserts.
- Flush: all busy bits clear at the next edge. Flush has priority over dispatch, wakeup and issue. A handshake completing in the flush cycle is discarded by the ALU (the ALU also sees flush).
- full = all slots busy, computed from current state. A slot freed by issue becomes usable only from the next cycle.

## Timing
- Reset values: all busy=0, full=0, issueValid=0, issueOp/issueA/issueB/issueTag=0.
- Dispatch → earliest issue: next cycle if both operands are ready at dispatch.
- CDB wakeup → issue: see Configuration.
- A slot dispatched and issued cannot happen in the same cycle.
- Simultaneous dispatch and issue with full=1: dispatch is blocked, and issue frees the slot at that edge.
- CDB tag matching both operands of one slot captures both.
- Reset mid-operation behaves identically to flush and also zeroes the outputs.

## Configuration
- RS_WAKE_ISSUE_BYPASS_EN defined: select also treats an operand as ready when it matches the current CDB broadcast. The bypassed cdbValue is muxed onto issueA/issueB, so wakeup → issue takes 0 extra cycles (same cycle).
- Undefined: select uses registered rdy bits only, so wakeup → issue takes 1 cycle. This gives a shorter CDB-to-ALU path.

## Structure
- Shared package rs_pkg: the rsOperand_t and rsEntry_t structs, the OP_W constant, and the ALU opcode enum.
- One sub-module, rs_prio_enc, is a parameterised lowest-index one-hot/index encoder. It is instantiated twice: free-slot select and ready-slot select.

## Test plan
- Reset, then dispatch op=ADD, A=5, B=7, both ready, dest=3 → next cycle issueValid=1, issueA=5, issueB=7, issueTag=3. With issueReady=1, the slot frees and issueValid=0 afterwards.
- Dispatch with ready1=0, rob1=2, then two cycles later CDB tag=2, value=0x10 → issueA=0x10. Issue occurs in the same cycle (BYPASS_EN) or the next cycle (without).
- Dispatch with ready2=0, rob2=6 while cdbValid, cdbTag=6, value=9 in the same cycle → operand captured, and the instruction issues next cycle with issueB=9.
- Fill four slots with unready operands → full=1, and a fifth dispatch is ignored. Wake slot 2 then slot 0 on the same cycle → slot 0 issues first. Hold issueReady=0 for 3 cycles → outputs stable.
- Fill slots, assert flush together with dispatch and issueReady → next cycle full=0, issueValid=0, and no slot is written.
- Two slots waiting on tag 4 with one broadcast → both capture, and they issue on consecutive cycles in index order.
